// File: rtl/dpc_pkg.sv
// Shared types and constants for the DPC test-pattern / defect-injection source.
package dpc_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StHblank = 2'd2,
    StVblank = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PatFlat    = 2'd0,
    PatColRamp = 2'd1,
    PatChecker = 2'd2,
    PatRowRamp = 2'd3
  } pattern_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [23:0] HOT_PIX   = 24'hFFFFFF;
  localparam logic [23:0] COLD_PIX  = 24'h000000;

  // One right-shifting Galois step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with seed load; an all-zero seed would lock up, so it maps to 1.
module lfsr16 import dpc_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (adv) begin
      q_d = lfsr_step(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 16'h0001;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dpc_defect_gen.sv
// Streaming RGB frame source with LFSR-driven stuck-hot/cold pixel injection and
// a per-beat ground-truth defect flag.
module dpc_defect_gen import dpc_pkg::*; #(
  parameter int H           = 720,
  parameter int V           = 480,
  parameter int HBLANK      = 16,
  parameter int VBLANK      = 4,
  parameter int DEFECT_RATE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  input  logic        inj_en,
  input  logic [15:0] seed,
  input  logic        pixel_ready,
  output logic [23:0] pixel_data_out,
  output logic        pixel_valid,
  output logic        sof,
  output logic        eol,
  output logic        defect_flag,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW   = (H > 1) ? $clog2(H) : 1;
  localparam int RW   = (V > 1) ? $clog2(V) : 1;
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V - 1);
  localparam logic [2:0]    GAP_SAT  = 3'd4;

  state_t        state_q, state_d;
  pattern_t      pat_q, pat_d;
  logic          inj_q, inj_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [2:0]    gap_q, gap_d;
  logic [23:0]   data_q, data_d;
  logic          valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic          flag_q, flag_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]   lfsr_q, b_lfsr;
  logic          lfsr_load, accept, load_cur, load_next, b_defect;
  logic [7:0]    b_base, col8, row8;

  assign lfsr_load = (state_q == StIdle) && start;
  assign accept    = valid_q && pixel_ready;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed),
    .adv  (accept),
    .q    (lfsr_q)
  );

  // col_q/row_q/gap_q always describe the beat on the outputs (or about to be loaded).
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    inj_d     = inj_q;
    col_d     = col_q;
    row_d     = row_q;
    blank_d   = blank_q;
    gap_d     = gap_q;
    load_cur  = 1'b0;
    load_next = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StActive;
          pat_d   = pattern_t'(pattern_sel);
          inj_d   = inj_en;
          col_d   = '0;
          row_d   = '0;
          gap_d   = GAP_SAT;
        end
      end
      StActive: begin
        if (!valid_q) begin
          load_cur = 1'b1;
        end else if (accept) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            gap_d   = GAP_SAT;
            blank_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = StVblank;
            end else begin
              state_d = StHblank;
              row_d   = row_q + 1'b1;
            end
          end else begin
            load_next = 1'b1;
            col_d     = col_q + 1'b1;
            gap_d     = flag_q ? 3'd0 : ((gap_q == GAP_SAT) ? GAP_SAT : gap_q + 3'd1);
          end
        end
      end
      StHblank: begin
        blank_d = blank_q + 1'b1;
        if (blank_q == BW'(HBLANK - 1)) begin
          state_d  = StActive;
          load_cur = 1'b1;
        end
      end
      StVblank: begin
        blank_d = blank_q + 1'b1;
        if (blank_q == BW'(VBLANK - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next beat is built from the post-update position; the LFSR is looked ahead on accept.
  always_comb begin
    b_lfsr = load_next ? lfsr_step(lfsr_q) : lfsr_q;
    col8   = 8'(col_d);
    row8   = 8'(row_d);
    unique case (pat_q)
      PatFlat:    b_base = 8'h80;
      PatColRamp: b_base = col8;
      PatChecker: b_base = (col8[3] ^ row8[3]) ? 8'hC0 : 8'h40;
      PatRowRamp: b_base = row8;
      default:    b_base = 8'h80;
    endcase
    b_defect = inj_q && ({24'd0, b_lfsr[7:0]} < 32'(DEFECT_RATE)) && (gap_d >= GAP_SAT) &&
               (32'(col_d) >= 32'd2) && (32'(col_d) <= 32'(H - 3)) &&
               (32'(row_d) >= 32'd2) && (32'(row_d) <= 32'(V - 3));
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    flag_d  = flag_q;
    if (load_cur || load_next) begin
      valid_d = 1'b1;
      data_d  = b_defect ? (b_lfsr[8] ? HOT_PIX : COLD_PIX) : {3{b_base}};
      sof_d   = (col_d == '0) && (row_d == '0);
      eol_d   = (col_d == COL_LAST);
      flag_d  = b_defect;
    end else if (accept) begin
      valid_d = 1'b0;
      data_d  = '0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      flag_d  = 1'b0;
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StVblank) && (blank_d == BW'(VBLANK - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pat_q   <= PatFlat;
      inj_q   <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      blank_q <= '0;
      gap_q   <= GAP_SAT;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      inj_q   <= inj_d;
      col_q   <= col_d;
      row_q   <= row_d;
      blank_q <= blank_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pixel_data_out = data_q;
  assign pixel_valid    = valid_q;
  assign sof            = sof_q;
  assign eol            = eol_q;
  assign defect_flag    = flag_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_dpc_defect_gen.sv
// Directed bench for dpc_defect_gen: a small 8x4 instance and a 16x8 injecting instance.
module tb_dpc_defect_gen;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HB = 16;
  localparam int VB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sel, inj_en, pixel_ready;
  logic [1:0]  pattern_sel;
  logic [15:0] seed;

  logic [23:0] data_a, data_b, pd;
  logic pv_a, sof_a, eol_a, flag_a, busy_a, fd_a;
  logic pv_b, sof_b, eol_b, flag_b, busy_b, fd_b;
  logic pv, psof, peol, pflag, pbusy, fd;
  logic start_a, start_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign pd    = sel ? data_b : data_a;
  assign pv    = sel ? pv_b   : pv_a;
  assign psof  = sel ? sof_b  : sof_a;
  assign peol  = sel ? eol_b  : eol_a;
  assign pflag = sel ? flag_b : flag_a;
  assign pbusy = sel ? busy_b : busy_a;
  assign fd    = sel ? fd_b   : fd_a;

  dpc_defect_gen #(.H(HA), .V(VA), .HBLANK(16), .VBLANK(4), .DEFECT_RATE(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pattern_sel(pattern_sel), .inj_en(inj_en),
    .seed(seed), .pixel_ready(pixel_ready), .pixel_data_out(data_a), .pixel_valid(pv_a),
    .sof(sof_a), .eol(eol_a), .defect_flag(flag_a), .busy(busy_a), .frame_done(fd_a)
  );

  dpc_defect_gen #(.H(HB), .V(VB), .HBLANK(16), .VBLANK(4), .DEFECT_RATE(255)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pattern_sel(pattern_sel), .inj_en(inj_en),
    .seed(seed), .pixel_ready(pixel_ready), .pixel_data_out(data_b), .pixel_valid(pv_b),
    .sof(sof_b), .eol(eol_b), .defect_flag(flag_b), .busy(busy_b), .frame_done(fd_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int start_cyc = 0;
  bit fd_busy = 1'b0;

  logic [23:0] cap_data[$];
  bit          cap_sof[$];
  bit          cap_eol[$];
  bit          cap_flag[$];
  int          cap_cyc[$];
  logic [23:0] exp_data[$];
  bit          exp_flag[$];

  bit          stall_prev = 1'b0;
  logic [27:0] prev_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) check("stall_hold", {4'd0, pv, psof, peol, pflag, pd}, {4'd0, prev_word});
      if (pv && pixel_ready) begin
        cap_data.push_back(pd);
        cap_sof.push_back(psof);
        cap_eol.push_back(peol);
        cap_flag.push_back(pflag);
        cap_cyc.push_back(cyc);
      end
      if (fd) begin
        fd_count = fd_count + 1;
        fd_cyc   = cyc;
        fd_busy  = pbusy;
      end
      stall_prev = pv && !pixel_ready;
      prev_word  = {pv, psof, peol, pflag, pd};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_caps();
    cap_data.delete(); cap_sof.delete(); cap_eol.delete(); cap_flag.delete(); cap_cyc.delete();
  endtask

  // poke: also pulse start mid-frame and in the frame_done cycle.
  task automatic run_frame(input bit s, input logic [1:0] pat, input bit inj,
                           input logic [15:0] sd, input bit rnd, input bit poke);
    int fd0;
    bit done;
    clear_caps();
    @(posedge clk); #1;
    sel = s; pattern_sel = pat; inj_en = inj; seed = sd; pixel_ready = 1'b1;
    start = 1'b1; start_cyc = cyc;
    fd0 = fd_count; done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      pixel_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (poke && (cap_data.size() == 5 || fd)) start = 1'b1;
      if (fd_count != fd0) done = 1'b1;
    end
    if (!done) check("frame_timeout", 32'd0, 32'd1);
    start = 1'b0;
    pixel_ready = 1'b1;
  endtask

  task automatic model_frame(input int h, input int v, input logic [1:0] pat, input bit inj,
                             input int rate, input logic [15:0] sd);
    logic [15:0] l;
    logic [7:0]  p;
    int g;
    bit d;
    exp_data.delete(); exp_flag.delete();
    l = (sd == 16'h0) ? 16'h1 : sd;
    g = 4;
    for (int r = 0; r < v; r++) begin
      for (int c = 0; c < h; c++) begin
        if (c == 0) g = 4;
        case (pat)
          2'd0: p = 8'h80;
          2'd1: p = c[7:0];
          2'd2: p = (c[3] ^ r[3]) ? 8'hC0 : 8'h40;
          default: p = r[7:0];
        endcase
        d = inj && (int'(l[7:0]) < rate) && (g >= 4) && c >= 2 && c <= h - 3 &&
            r >= 2 && r <= v - 3;
        exp_data.push_back(d ? (l[8] ? 24'hFFFFFF : 24'h000000) : {p, p, p});
        exp_flag.push_back(d);
        g = d ? 0 : ((g < 4) ? g + 1 : 4);
        l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      end
    end
  endtask

  task automatic cmp_model(input string name);
    check({name, "_count"}, cap_data.size(), exp_data.size());
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
      check({name, "_beat"}, {7'd0, cap_flag[i], cap_data[i]}, {7'd0, exp_flag[i], exp_data[i]});
    end
  endtask

  typedef struct packed {
    logic [1:0]  pat;
    int          idx;
    logic [23:0] data;
    logic        sof;
    logic        eol;
  } vec_t;

  vec_t        vecs[12];
  logic [23:0] saved_data[$];
  bit          saved_flag[$];

  initial begin : main
    int fd0, nmis, ndef, last;
    bit hit;

    vecs[0]  = '{pat: 2'd0, idx: 0,   data: 24'h808080, sof: 1'b1, eol: 1'b0};
    vecs[1]  = '{pat: 2'd0, idx: 127, data: 24'h808080, sof: 1'b0, eol: 1'b1};
    vecs[2]  = '{pat: 2'd1, idx: 17,  data: 24'h010101, sof: 1'b0, eol: 1'b0};
    vecs[3]  = '{pat: 2'd1, idx: 31,  data: 24'h0F0F0F, sof: 1'b0, eol: 1'b1};
    vecs[4]  = '{pat: 2'd1, idx: 40,  data: 24'h080808, sof: 1'b0, eol: 1'b0};
    vecs[5]  = '{pat: 2'd2, idx: 0,   data: 24'h404040, sof: 1'b1, eol: 1'b0};
    vecs[6]  = '{pat: 2'd2, idx: 8,   data: 24'hC0C0C0, sof: 1'b0, eol: 1'b0};
    vecs[7]  = '{pat: 2'd2, idx: 15,  data: 24'hC0C0C0, sof: 1'b0, eol: 1'b1};
    vecs[8]  = '{pat: 2'd2, idx: 119, data: 24'h404040, sof: 1'b0, eol: 1'b0};
    vecs[9]  = '{pat: 2'd3, idx: 16,  data: 24'h010101, sof: 1'b0, eol: 1'b0};
    vecs[10] = '{pat: 2'd3, idx: 50,  data: 24'h030303, sof: 1'b0, eol: 1'b0};
    vecs[11] = '{pat: 2'd3, idx: 127, data: 24'h070707, sof: 1'b0, eol: 1'b1};

    rst = 1'b1; start = 1'b0; sel = 1'b0; inj_en = 1'b0; pixel_ready = 1'b1;
    pattern_sel = 2'd0; seed = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", {2'd0, data_a, pv_a, sof_a, eol_a, flag_a, busy_a, fd_a}, 32'd0);
    check("reset_b", {2'd0, data_b, pv_b, sof_b, eol_b, flag_b, busy_b, fd_b}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Flat pattern, ready held high, small geometry.
    run_frame(1'b0, 2'd0, 1'b0, 16'h1, 1'b0, 1'b0);
    check("p0_count", cap_data.size(), HA * VA);
    if (cap_data.size() == HA * VA) begin
      for (int i = 0; i < HA * VA; i++) begin
        check("p0_beat", {5'd0, cap_sof[i], cap_eol[i], cap_flag[i], cap_data[i]},
              {5'd0, (i == 0), (i % HA == HA - 1), 1'b0, 24'h808080});
      end
      check("start_latency", cap_cyc[0] - start_cyc, 2);
      for (int ln = 1; ln < VA; ln++) begin
        check("hblank_gap", cap_cyc[ln * HA] - cap_cyc[ln * HA - 1], 17);
      end
      check("frame_done_delay", fd_cyc - cap_cyc[HA * VA - 1], 4);
    end
    check("busy_at_done", fd_busy, 1);
    @(negedge clk);
    check("idle_after_frame", {pbusy, pv, fd}, 3'b000);

    // Column ramp under random back-pressure.
    run_frame(1'b0, 2'd1, 1'b0, 16'h1, 1'b1, 1'b0);
    check("p1_count", cap_data.size(), HA * VA);
    for (int i = 0; i < cap_data.size() && i < HA * VA; i++) begin
      check("p1_beat", cap_data[i], {3{8'(i % HA)}});
    end

    // Hand-computed spot checks of every pattern on the 16x8 instance.
    for (int p = 0; p < 4; p++) begin
      run_frame(1'b1, 2'(p), 1'b0, 16'h1, 1'b0, 1'b0);
      check("pat_count", cap_data.size(), HB * VB);
      for (int k = 0; k < 12; k++) begin
        if (vecs[k].pat == 2'(p) && vecs[k].idx < cap_data.size()) begin
          check($sformatf("pat%0d_idx%0d", p, vecs[k].idx),
                {6'd0, cap_sof[vecs[k].idx], cap_eol[vecs[k].idx], cap_data[vecs[k].idx]},
                {6'd0, vecs[k].sof, vecs[k].eol, vecs[k].data});
        end
      end
    end

    // Injection with stalls, checked against a reference model and geometric rules.
    run_frame(1'b1, 2'd0, 1'b1, 16'hACE1, 1'b1, 1'b0);
    model_frame(HB, VB, 2'd0, 1'b1, 255, 16'hACE1);
    cmp_model("inj_ace1");
    ndef = 0; last = -100;
    for (int i = 0; i < cap_data.size(); i++) begin
      if (cap_flag[i]) begin
        ndef++;
        hit = (i % HB >= 2) && (i % HB <= HB - 3) && (i / HB >= 2) && (i / HB <= VB - 3);
        check("defect_window", hit, 1);
        check("defect_spacing", (i - last) >= 4, 1);
        check("defect_value", (cap_data[i] == 24'hFFFFFF) || (cap_data[i] == 24'h0), 1);
        last = i;
      end
    end
    check("defect_seen", ndef > 0, 1);
    saved_flag = cap_flag;

    run_frame(1'b1, 2'd0, 1'b1, 16'hACE1, 1'b0, 1'b0);
    nmis = 0;
    for (int i = 0; i < HB * VB; i++) begin
      if (i >= cap_flag.size() || i >= saved_flag.size() || cap_flag[i] != saved_flag[i]) nmis++;
    end
    check("same_seed_repeat", nmis, 0);

    // Seed 0 must behave exactly like seed 1.
    run_frame(1'b1, 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0);
    saved_data = cap_data;
    saved_flag = cap_flag;
    model_frame(HB, VB, 2'd2, 1'b1, 255, 16'h0001);
    cmp_model("seed0");
    run_frame(1'b1, 2'd2, 1'b1, 16'h0001, 1'b0, 1'b0);
    nmis = 0;
    for (int i = 0; i < HB * VB; i++) begin
      if (i >= cap_data.size() || i >= saved_data.size() || cap_data[i] != saved_data[i] ||
          cap_flag[i] != saved_flag[i]) nmis++;
    end
    check("seed0_eq_seed1", nmis, 0);

    // start while busy and in the frame_done cycle is ignored.
    fd0 = fd_count;
    run_frame(1'b0, 2'd0, 1'b0, 16'h1, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("poke_one_done", fd_count - fd0, 1);
    check("poke_beats", cap_data.size(), HA * VA);
    check("poke_not_busy", pbusy, 0);

    // Reset in the middle of a line.
    clear_caps();
    @(posedge clk); #1;
    sel = 1'b0; pattern_sel = 2'd0; inj_en = 1'b0; pixel_ready = 1'b1; start = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cap_data.size() == 5) hit = 1'b1;
    end
    check("rst_reach_beat5", hit, 1);
    fd0 = fd_count;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {2'd0, data_a, pv_a, sof_a, eol_a, flag_a, busy_a, fd_a}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("rst_no_done", fd_count - fd0, 0);
    run_frame(1'b0, 2'd0, 1'b0, 16'h1, 1'b0, 1'b0);
    check("restart_count", cap_data.size(), HA * VA);
    if (cap_data.size() > 0) check("restart_first", {7'd0, cap_sof[0], cap_data[0]},
                                   {7'd0, 1'b1, 24'h808080});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
